key_debouncer: RTL and testbench

- Conditions a raw mechanical push-button into clean, glitch-free key events for the downstream counter, PRNG and LED logic.
- Sits between the board pin and any logic that samples a key level or acts on key edges.
- Pipeline: two-flop synchroniser, then a debounce state machine, then registered level, press, release and long-press outputs.

---
 rtl/key_debouncer_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/key_debouncer.sv | 105 ++++++++++
 tb/tb_key_debouncer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg: shared FSM encodings and board-level timing constants
package key_debouncer_pkg;
    typedef enum logic [1:0] {
        KEY_IDLE         = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_PRESSED      = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned CLK_HZ = 27_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return CLK_HZ / 1000 * ms;
    endfunction

    localparam int unsigned DEF_DEBOUNCE_CYCLES = ms_to_cycles(10);
    localparam int unsigned DEF_LONG_CYCLES     = ms_to_cycles(1000);
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous pin, with a selectable reset level
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: synchronises and debounces a push-button into a clean level plus
// press, release and long-press pulses.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic key_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    key_state_t         r_state;
    logic [DB_W-1:0]    r_db;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_long_done;
    logic               w_s;
    logic               w_p;
    logic               w_holding;
    logic               w_rel_acc;

    sync_2ff #(.RST_VAL(KEY_ACTIVE_LOW)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (key_i),
        .o_q (w_s)
    );

    assign w_p       = w_s ^ KEY_ACTIVE_LOW;
    assign w_holding = (r_state == KEY_PRESSED) || (r_state == KEY_RELEASE_WAIT);
    assign w_rel_acc = (r_state == KEY_RELEASE_WAIT) && !w_p && (r_db == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= KEY_IDLE;
            r_db        <= '0;
            r_hold      <= '0;
            r_long_done <= 1'b0;
            key_o       <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            long_o      <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            // a release accepted on the expiry edge suppresses the long pulse
            if (w_holding && !w_rel_acc) begin
                if (r_hold != HOLD_MAX)
                    r_hold <= r_hold + HOLD_W'(1);
                if (r_hold == HOLD_LAST && !r_long_done) begin
                    long_o      <= 1'b1;
                    r_long_done <= 1'b1;
                end
            end
            case (r_state)
                KEY_IDLE: begin
                    if (w_p) begin
                        r_state <= KEY_PRESS_WAIT;
                        r_db    <= '0;
                    end
                end
                KEY_PRESS_WAIT: begin
                    if (!w_p)
                        r_state <= KEY_IDLE;
                    else if (r_db == DB_LAST) begin
                        r_state <= KEY_PRESSED;
                        key_o   <= 1'b1;
                        press_o <= 1'b1;
                        r_hold  <= '0;
                    end else
                        r_db <= r_db + DB_W'(1);
                end
                KEY_PRESSED: begin
                    if (!w_p) begin
                        r_state <= KEY_RELEASE_WAIT;
                        r_db    <= '0;
                    end
                end
                KEY_RELEASE_WAIT: begin
                    if (w_p)
                        r_state <= KEY_PRESSED;
                    else if (r_db == DB_LAST) begin
                        r_state     <= KEY_IDLE;
                        key_o       <= 1'b0;
                        release_o   <= 1'b1;
                        r_long_done <= 1'b0;
                    end else
                        r_db <= r_db + DB_W'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed latency checks plus random bouncing against a run-length reference model
module tb_key_debouncer;
    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b01;
    logic [1:0] ko, po, ro, lo;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    key_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .KEY_ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .key_i(key[0]),
        .key_o(ko[0]), .press_o(po[0]), .release_o(ro[0]), .long_o(lo[0])
    );
    key_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .KEY_ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .key_i(key[1]),
        .key_o(ko[1]), .press_o(po[1]), .release_o(ro[1]), .long_o(lo[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference: the accepted level flips once D+1 consecutive samples disagree with it;
    // samples reach the decision two edges after the pin. Long fires L edges after a press.
    bit m_k1[2], m_k2[2], m_lvl[2], e_press[2], e_rel[2], e_long[2];
    int m_run[2], m_since[2];

    always @(posedge clk or posedge rst) begin : model
        bit p;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_k1[u] = (u == 0);
                m_k2[u] = (u == 0);
                m_lvl[u] = 1'b0;
                m_run[u] = 0;
                m_since[u] = 0;
                e_press[u] = 1'b0;
                e_rel[u] = 1'b0;
                e_long[u] = 1'b0;
            end else begin
                p = m_k2[u] ^ (u == 0);
                m_k2[u] = m_k1[u];
                m_k1[u] = key[u];
                e_press[u] = 1'b0;
                e_rel[u] = 1'b0;
                e_long[u] = 1'b0;
                m_run[u] = (p != m_lvl[u]) ? m_run[u] + 1 : 0;
                if (m_run[u] == D + 1) begin
                    m_lvl[u] = p;
                    m_run[u] = 0;
                    e_press[u] = p;
                    e_rel[u] = !p;
                    m_since[u] = 0;
                end else if (m_lvl[u]) begin
                    m_since[u]++;
                    e_long[u] = (m_since[u] == L);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("key_o[%0d]", u), ko[u], m_lvl[u]);
                chk($sformatf("press_o[%0d]", u), po[u], e_press[u]);
                chk($sformatf("release_o[%0d]", u), ro[u], e_rel[u]);
                chk($sformatf("long_o[%0d]", u), lo[u], e_long[u]);
            end
        end
    end

    function automatic bit pick(input int sel);
        case (sel)
            0: return po[0];
            1: return ro[0];
            2: return lo[0];
            3: return po[1];
            default: return ro[1];
        endcase
    endfunction

    task automatic count_to(input int sel, output int n);
        int i = 0;
        n = -1;
        while (n < 0 && i < 40) begin
            @(posedge clk);
            #1;
            i++;
            if (pick(sel)) n = i;
        end
    endtask

    initial begin
        int n;
        int run[2];
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_key", ko[0], 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        key[0] = 1'b0;
        count_to(0, n);
        chk("press_lat", n, D + 3);
        count_to(2, n);
        chk("long_lat", n, L);
        repeat (20) @(negedge clk);
        key[0] = 1'b1;
        count_to(1, n);
        chk("release_lat", n, D + 3);
        chk("release_key", ko[0], 0);
        repeat (30) @(negedge clk);
        for (int r = 0; r < 10; r++) begin
            key[0] = 1'b0;
            repeat (4) @(negedge clk);
            key[0] = 1'b1;
            @(negedge clk);
        end
        chk("bounce_key", ko[0], 0);
        key[0] = 1'b0;
        count_to(0, n);
        chk("post_bounce_lat", n, D + 3);
        @(negedge clk);
        key[0] = 1'b1;
        repeat (20) @(negedge clk);
        key[0] = 1'b0;
        count_to(0, n);
        chk("collide_press", n, D + 3);
        repeat (14) @(negedge clk);
        key[0] = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("collide_rel", ro[0], 1);
        chk("collide_long", lo[0], 0);
        repeat (20) @(negedge clk);
        key[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("pw_rst_key", ko[0], 0);
        rst = 1'b0;
        count_to(0, n);
        chk("rst_repress", n, D + 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_key", ko[0], 0);
        @(negedge clk);
        rst = 1'b0;
        key[0] = 1'b1;
        repeat (15) @(negedge clk);
        key[1] = 1'b1;
        count_to(3, n);
        chk("hi_press_lat", n, D + 3);
        chk("hi_key", ko[1], 1);
        repeat (3) @(negedge clk);
        key[1] = 1'b0;
        count_to(4, n);
        chk("hi_release_lat", n, D + 3);
        chk("hi_key_rel", ko[1], 0);
        run = '{0, 0};
        repeat (3000) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (run[u] == 0) begin
                    key[u] = ~key[u];
                    run[u] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 8);
                end
                run[u]--;
            end
        end
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
